// File: rtl/inst_cache_pkg.sv
// Shared constants and FSM encoding for the instruction cache.
// Imported by the cache interface, line array and top.
package inst_cache_pkg;

    localparam int ICACHE_INDEX_BITS = 6;
    localparam int ICACHE_ADDR_W = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } state_e;

endpackage

// File: rtl/inst_cache_if.sv
// IF-side fetch port and memory-controller read port of the cache.
// slave = cache side, master = IF stage plus memory controller.
interface inst_cache_if
    import inst_cache_pkg::*;
#(
    parameter int ADDR_W = ICACHE_ADDR_W
);
    logic              rdy;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_cancel;
    logic              inv_all;
    logic              if_valid;
    logic [31:0]       if_data;
    logic              if_busy;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [31:0]       mem_rdata;
    logic              mem_rbusy;

    modport slave (
        input  rdy, if_req, if_addr, if_cancel, inv_all,
        input  mem_rdata, mem_rbusy,
        output if_valid, if_data, if_busy,
        output mem_re, mem_raddr
    );

    modport master (
        output rdy, if_req, if_addr, if_cancel, inv_all,
        output mem_rdata, mem_rbusy,
        input  if_valid, if_data, if_busy,
        input  mem_re, mem_raddr
    );
endinterface

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage: async read, one write port, bulk invalidate.
// Tag and data words are never reset; only the valid bits are.
module inst_cache_array #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_W      = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  inv_all,
    input  logic [INDEX_BITS-1:0] ridx,
    output logic                  rvalid,
    output logic [TAG_W-1:0]      rtag,
    output logic [31:0]           rdata,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] widx,
    input  logic [TAG_W-1:0]      wtag,
    input  logic [31:0]           wdata,
    input  logic                  wvalid
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    // A fill in the same cycle as inv_all wins for its own line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (en) begin
            if (inv_all) valid <= '0;
            if (we) valid[widx] <= wvalid;
        end
    end

    always_ff @(posedge clk) begin
        if (en && we) begin
            tag_mem[widx]  <= wtag;
            data_mem[widx] <= wdata;
        end
    end

    assign rvalid = valid[ridx];
    assign rtag   = tag_mem[ridx];
    assign rdata  = data_mem[ridx];
endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache between IF and memory.
// Hits answer on the next edge; misses issue one word read and fill the line.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int ADDR_W     = ICACHE_ADDR_W
) (
    input logic clk,
    input logic rst,
    inst_cache_if.slave bus
);
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    state_e state, state_n;
    logic [ADDR_W-1:0] raddr_q, raddr_n;
    logic [31:0] if_data_q, if_data_n;
    logic if_valid_q, if_valid_n;
    logic if_busy_q, if_busy_n;
    logic mem_re_q, mem_re_n;
    logic drop_q, drop_n;
    logic inv_q, inv_n;

    logic rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0] rd_data;
    logic arr_we, arr_wvalid, hit;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^bus.if_addr[1:0];

    inst_cache_array #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .en     (bus.rdy),
        .inv_all(bus.inv_all),
        .ridx   (bus.if_addr[INDEX_BITS+1:2]),
        .rvalid (rd_valid),
        .rtag   (rd_tag),
        .rdata  (rd_data),
        .we     (arr_we),
        .widx   (raddr_q[INDEX_BITS+1:2]),
        .wtag   (raddr_q[ADDR_W-1:INDEX_BITS+2]),
        .wdata  (bus.mem_rdata),
        .wvalid (arr_wvalid)
    );

    assign hit = rd_valid
               && (rd_tag == bus.if_addr[ADDR_W-1:INDEX_BITS+2]);

    always_comb begin
        state_n    = state;
        raddr_n    = raddr_q;
        if_data_n  = if_data_q;
        if_valid_n = 1'b0;
        if_busy_n  = if_busy_q;
        mem_re_n   = mem_re_q;
        // cancel/invalidate seen mid-miss are remembered until the fill
        drop_n     = drop_q | (bus.if_cancel && state != S_IDLE);
        inv_n      = inv_q | (bus.inv_all && state != S_IDLE);
        arr_we     = 1'b0;
        arr_wvalid = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.if_req) begin
                    if (hit && !bus.inv_all) begin
                        if_valid_n = !bus.if_cancel;
                        if (!bus.if_cancel) if_data_n = rd_data;
                    end else begin
                        raddr_n   = {bus.if_addr[ADDR_W-1:2], 2'b00};
                        mem_re_n  = 1'b1;
                        if_busy_n = 1'b1;
                        drop_n    = bus.if_cancel;
                        inv_n     = 1'b0;
                        state_n   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_rbusy) begin
                    mem_re_n = 1'b0;
                    state_n  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.mem_rbusy) begin
                    arr_we     = 1'b1;
                    arr_wvalid = !(inv_q || bus.inv_all);
                    if_valid_n = !(drop_q || bus.if_cancel);
                    if (if_valid_n) if_data_n = bus.mem_rdata;
                    if_busy_n  = 1'b0;
                    drop_n     = 1'b0;
                    inv_n      = 1'b0;
                    state_n    = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            raddr_q    <= '0;
            if_data_q  <= ZERO_WORD;
            if_valid_q <= 1'b0;
            if_busy_q  <= 1'b0;
            mem_re_q   <= 1'b0;
            drop_q     <= 1'b0;
            inv_q      <= 1'b0;
        end else if (bus.rdy) begin
            state      <= state_n;
            raddr_q    <= raddr_n;
            if_data_q  <= if_data_n;
            if_valid_q <= if_valid_n;
            if_busy_q  <= if_busy_n;
            mem_re_q   <= mem_re_n;
            drop_q     <= drop_n;
            inv_q      <= inv_n;
        end
    end

    assign bus.if_valid  = if_valid_q;
    assign bus.if_data   = if_data_q;
    assign bus.if_busy   = if_busy_q;
    assign bus.mem_re    = mem_re_q & bus.rdy;
    assign bus.mem_raddr = raddr_q;
endmodule

// File: tb/tb_inst_cache.sv
// Randomized scoreboard bench for inst_cache with a memory controller model.
// A tag/valid reference model predicts hits, misses and response data.
module tb_inst_cache;
    localparam int M_NORM   = 0;
    localparam int M_CANCEL = 1;
    localparam int M_INVMID = 2;
    localparam int M_INVREQ = 3;

    typedef struct {
        logic [31:0] data;
        int          reads;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    inst_cache_if #(.ADDR_W(32)) bus();

    inst_cache #(.INDEX_BITS(6), .ADDR_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    exp_t sb[$];
    int model_reads = 0;
    int reads = 0;
    logic [31:0] exp_raddr = 32'h0;
    bit ref_valid [64];
    logic [23:0] ref_tag [64];
    int busy_len = 8;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0000_1000) return 32'h0010_0093;
        return (w * 32'h9E37_79B9) ^ 32'hA5A5_0013;
    endfunction

    // memory controller: busy rises with mem_re, lasts busy_len cycles
    logic ctrl_busy;
    int ctrl_cnt;
    logic [31:0] ctrl_addr;
    assign bus.mem_rbusy = ctrl_busy | bus.mem_re;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_busy <= 1'b0;
            ctrl_cnt <= 0;
        end else if (bus.mem_re && !ctrl_busy) begin
            ctrl_busy <= 1'b1;
            ctrl_cnt <= busy_len - 1;
            ctrl_addr <= bus.mem_raddr;
            reads <= reads + 1;
        end else if (ctrl_busy) begin
            if (ctrl_cnt <= 1) begin
                ctrl_busy <= 1'b0;
                bus.mem_rdata <= mem_word(ctrl_addr);
            end else begin
                ctrl_cnt <= ctrl_cnt - 1;
            end
        end
    end

    // response monitor and read-port monitor
    logic prev_re = 1'b0;
    always @(negedge clk) begin
        if (!rst && bus.if_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_data", bus.if_data, e.data);
                chk("resp_mem_reads", reads, e.reads);
                chk("busy_with_valid", {31'd0, bus.if_busy}, 32'd0);
            end
        end
        if (!rst && bus.mem_re) begin
            chk("mem_raddr", bus.mem_raddr, exp_raddr);
            chk("mem_re_pulse", {31'd0, prev_re}, 32'd0);
        end
        prev_re = bus.mem_re;
    end

    task automatic clear_ref();
        foreach (ref_valid[i]) ref_valid[i] = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input int mode);
        int idx, n;
        logic [23:0] tg;
        bit miss, deliver;
        idx = int'(a[7:2]);
        tg = a[31:8];
        if (mode == M_INVREQ) clear_ref();
        miss = !(ref_valid[idx] && ref_tag[idx] == tg);
        deliver = (mode != M_CANCEL);
        if (miss) begin
            model_reads++;
            exp_raddr = {a[31:2], 2'b00};
        end
        if (deliver) sb.push_back('{mem_word(a), model_reads});
        @(negedge clk);
        bus.if_req = 1'b1;
        bus.if_addr = a;
        bus.if_cancel = (mode == M_CANCEL) && !miss;
        bus.inv_all = (mode == M_INVREQ);
        @(negedge clk);
        bus.if_req = 1'b0;
        bus.if_cancel = 1'b0;
        bus.inv_all = 1'b0;
        bus.if_addr = $urandom;
        if (!miss) begin
            chk("hit_valid", {31'd0, bus.if_valid}, {31'd0, deliver});
            chk("hit_not_busy", {31'd0, bus.if_busy}, 32'd0);
        end else begin
            chk("miss_busy", {31'd0, bus.if_busy}, 32'd1);
            @(negedge clk);
            bus.if_cancel = (mode == M_CANCEL);
            bus.inv_all = (mode == M_INVMID);
            @(negedge clk);
            bus.if_cancel = 1'b0;
            bus.inv_all = 1'b0;
            n = 0;
            while (bus.if_busy && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("miss_timeout", {31'd0, n >= 200}, 32'd0);
            chk("fill_valid", {31'd0, bus.if_valid}, {31'd0, deliver});
            if (mode == M_INVMID) clear_ref();
            ref_tag[idx] = tg;
            ref_valid[idx] = (mode != M_INVMID);
        end
    endtask

    task automatic inv_idle();
        @(negedge clk);
        bus.inv_all = 1'b1;
        @(negedge clk);
        bus.inv_all = 1'b0;
        clear_ref();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int r;
        bus.rdy = 1'b1;
        bus.if_req = 1'b0;
        bus.if_addr = 32'h0;
        bus.if_cancel = 1'b0;
        bus.inv_all = 1'b0;
        bus.mem_rdata = 32'h0;
        clear_ref();
        foreach (ref_tag[i]) ref_tag[i] = 24'h0;
        repeat (2) @(negedge clk);
        chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_if_busy", {31'd0, bus.if_busy}, 32'd0);
        chk("rst_mem_re", {31'd0, bus.mem_re}, 32'd0);
        chk("rst_mem_raddr", bus.mem_raddr, 32'd0);
        chk("rst_if_data", bus.if_data, 32'd0);
        rst = 1'b0;

        busy_len = 8;
        fetch(32'h0000_1000, M_NORM);
        fetch(32'h0000_1000, M_NORM);
        fetch(32'h0000_1100, M_NORM);
        fetch(32'h0000_1000, M_NORM);
        fetch(32'h0000_2000, M_CANCEL);
        fetch(32'h0000_2000, M_NORM);
        fetch(32'h0000_1000, M_NORM);
        fetch(32'h0000_1004, M_NORM);
        inv_idle();
        fetch(32'h0000_1000, M_NORM);
        fetch(32'h0000_1004, M_NORM);
        fetch(32'h0000_1004, M_INVREQ);
        fetch(32'h0000_1004, M_NORM);
        fetch(32'h0000_1008, M_INVMID);
        fetch(32'h0000_1008, M_NORM);
        fetch(32'h0000_1008, M_CANCEL);

        // freeze with rdy=0 across the cycle where mem_rbusy falls
        model_reads++;
        exp_raddr = 32'h0000_3000;
        sb.push_back('{mem_word(32'h3000), model_reads});
        @(negedge clk);
        bus.if_req = 1'b1;
        bus.if_addr = 32'h0000_3000;
        @(negedge clk);
        bus.if_req = 1'b0;
        repeat (4) @(negedge clk);
        bus.rdy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("frz_busy", {31'd0, bus.if_busy}, 32'd1);
            chk("frz_valid", {31'd0, bus.if_valid}, 32'd0);
            chk("frz_mem_re", {31'd0, bus.mem_re}, 32'd0);
        end
        bus.rdy = 1'b1;
        @(negedge clk);
        chk("frz_release", {31'd0, bus.if_valid}, 32'd1);
        ref_valid[0] = 1'b1;
        ref_tag[0] = 24'h000030;

        // reset in the middle of a miss
        model_reads++;
        exp_raddr = 32'h0000_1000;
        @(negedge clk);
        bus.if_req = 1'b1;
        bus.if_addr = 32'h0000_1000;
        @(negedge clk);
        bus.if_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, bus.if_busy}, 32'd0);
        chk("midrst_mem_re", {31'd0, bus.mem_re}, 32'd0);
        clear_ref();
        @(negedge clk);
        rst = 1'b0;
        fetch(32'h0000_1000, M_NORM);

        for (int k = 0; k < 200; k++) begin
            busy_len = $urandom_range(2, 9);
            a = {$urandom_range(0, 3) == 0 ? 24'hFFFFFF : 24'h000010
                 + 24'($urandom_range(0, 2)),
                 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            r = $urandom_range(0, 9);
            if (r == 0) begin
                fetch(a, M_CANCEL);
            end else if (r == 1) begin
                if (ref_valid[a[7:2]] && ref_tag[a[7:2]] == a[31:8])
                    fetch(a, M_INVREQ);
                else
                    fetch(a, M_INVMID);
            end else if (r == 2) begin
                inv_idle();
            end else if (r == 3) begin
                fetch(a, M_INVREQ);
            end else begin
                fetch(a, M_NORM);
            end
        end

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
